// File: rtl/board_judge.sv
// 3x3 board responder: accepts cell writes, scans the 8 winning lines after each
// accepted move and reports win/tie through gameIsDone/winner.
module board_judge #(
  parameter int LINES_PER_CYCLE = 1
) (
  input  logic        ph1,
  input  logic        ph2,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic [1:0]  cellState,
  output logic        gameIsDone,
  output logic [1:0]  winner,
  output logic        illegalMove,
  output logic        busy,
  output logic [17:0] board
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         NUM_GROUPS = 8 / LINES_PER_CYCLE;
  localparam logic [2:0] LAST_GROUP = 3'(NUM_GROUPS - 1);
  localparam logic [3:0] NO_WRITE   = 4'b1111;
  localparam logic [1:0] EMPTY      = 2'b00;
  localparam logic [1:0] TIE        = 2'b01;

  state_e      state_d, state_m, state_q;
  logic [17:0] board_d, board_m, board_q;
  logic [3:0]  move_cnt_d, move_cnt_m, move_cnt_q;
  logic [2:0]  group_d, group_m, group_q;
  logic        done_d, done_m, done_q;
  logic [1:0]  winner_d, winner_m, winner_q;
  logic        illegal_d, illegal_m, illegal_q;

  logic        write_req;
  logic        addr_ok;
  logic [3:0]  cell_sel;
  logic [1:0]  target;
  logic        accept;
  logic        win_found;
  logic [1:0]  win_val;
  logic [2:0]  line_res;

  // Returns {win, value} for one winning line of the given board.
  function automatic logic [2:0] eval_line(input logic [17:0] b, input logic [2:0] ln);
    logic [3:0] ca, cb, cc;
    logic [1:0] va, vb, vc;
    case (ln)
      3'd0:    begin ca = 4'd0; cb = 4'd1; cc = 4'd2; end
      3'd1:    begin ca = 4'd3; cb = 4'd4; cc = 4'd5; end
      3'd2:    begin ca = 4'd6; cb = 4'd7; cc = 4'd8; end
      3'd3:    begin ca = 4'd0; cb = 4'd3; cc = 4'd6; end
      3'd4:    begin ca = 4'd1; cb = 4'd4; cc = 4'd7; end
      3'd5:    begin ca = 4'd2; cb = 4'd5; cc = 4'd8; end
      3'd6:    begin ca = 4'd0; cb = 4'd4; cc = 4'd8; end
      default: begin ca = 4'd2; cb = 4'd4; cc = 4'd6; end
    endcase
    va = b[{ca, 1'b0} +: 2];
    vb = b[{cb, 1'b0} +: 2];
    vc = b[{cc, 1'b0} +: 2];
    return {(va != EMPTY) && (va == vb) && (vb == vc), va};
  endfunction

  // Scan the current group; iterate downward so the lowest line index decides.
  always_comb begin
    win_found = 1'b0;
    win_val   = 2'b00;
    line_res  = 3'b000;
    for (int j = LINES_PER_CYCLE - 1; j >= 0; j--) begin
      line_res = eval_line(board_q, 3'(int'(group_q) * LINES_PER_CYCLE + j));
      if (line_res[2]) begin
        win_found = 1'b1;
        win_val   = line_res[1:0];
      end
    end
  end

  always_comb begin
    write_req = (addr != NO_WRITE) && (state_q != DONE);
    addr_ok   = (addr <= 4'd8);
    cell_sel  = addr_ok ? addr : 4'd0;
    target    = board_q[{cell_sel, 1'b0} +: 2];
    accept    = write_req && addr_ok && (cellState != EMPTY) && (target == EMPTY);
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    move_cnt_d = move_cnt_q;
    group_d    = group_q;
    done_d     = done_q;
    winner_d   = winner_q;
    illegal_d  = write_req && !accept;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
          group_d = 3'd0;
        end
      end
      SCAN: begin
        if (accept) begin
          group_d = 3'd0;
        end else if (win_found) begin
          state_d  = DONE;
          done_d   = 1'b1;
          winner_d = win_val;
        end else if (group_q == LAST_GROUP) begin
          group_d = 3'd0;
          if (move_cnt_q == 4'd9) begin
            state_d  = DONE;
            done_d   = 1'b1;
            winner_d = TIE;
          end else begin
            state_d  = IDLE;
            winner_d = 2'b00;
          end
        end else begin
          group_d = group_q + 3'd1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      board_d[{cell_sel, 1'b0} +: 2] = cellState;
      move_cnt_d                     = move_cnt_q + 4'd1;
    end

    if (reset) begin
      state_d    = IDLE;
      board_d    = '0;
      move_cnt_d = '0;
      group_d    = '0;
      done_d     = 1'b0;
      winner_d   = 2'b00;
      illegal_d  = 1'b0;
    end
  end

  // Two-phase flop: master captures at the close of ph2, slave launches on ph1.
  always_ff @(negedge ph2) begin
    state_m    <= state_d;
    board_m    <= board_d;
    move_cnt_m <= move_cnt_d;
    group_m    <= group_d;
    done_m     <= done_d;
    winner_m   <= winner_d;
    illegal_m  <= illegal_d;
  end

  always_ff @(posedge ph1) begin
    state_q    <= state_m;
    board_q    <= board_m;
    move_cnt_q <= move_cnt_m;
    group_q    <= group_m;
    done_q     <= done_m;
    winner_q   <= winner_m;
    illegal_q  <= illegal_m;
  end

  assign gameIsDone  = done_q;
  assign winner      = winner_q;
  assign illegalMove = illegal_q;
  assign busy        = (state_q == SCAN);
  assign board       = board_q;

endmodule

// File: tb/tb_board_judge.sv
// Directed bench for board_judge: one line per cycle and all eight lines per cycle.
module tb_board_judge;

  logic        ph1, ph2, reset;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic        done1, done8, ill1, ill8, busy1, busy8;
  logic [1:0]  win1, win8;
  logic [17:0] board1, board8;
  int          checks;
  int          failures;

  board_judge #(.LINES_PER_CYCLE(1)) dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .addr(addr), .cellState(cellState),
    .gameIsDone(done1), .winner(win1), .illegalMove(ill1), .busy(busy1), .board(board1)
  );

  board_judge #(.LINES_PER_CYCLE(8)) dut8 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .addr(addr), .cellState(cellState),
    .gameIsDone(done8), .winner(win8), .illegalMove(ill8), .busy(busy8), .board(board8)
  );

  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      #1 ph1 = 1'b1;
      #4 ph1 = 1'b0;
      #1 ph2 = 1'b1;
      #3 ph2 = 1'b0;
      #1;
    end
  end

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    addr      = 4'hF;
    cellState = 2'b00;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Drives a write for one cycle; returns one cycle later with inputs idle.
  task automatic wr(input logic [3:0] a, input logic [1:0] s);
    addr      = a;
    cellState = s;
    step();
    addr      = 4'hF;
    cellState = 2'b00;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    checks++; if (board1 !== 18'h0) begin failures++; $display("FAIL reset_board: got %h expected %h", board1, 18'h0); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done1); end
    checks++; if (win1 !== 2'b00) begin failures++; $display("FAIL reset_winner: got %b expected 00", win1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (ill1 !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b expected 0", ill1); end
  endtask

  task automatic test_row_win();
    apply_reset();
    wr(4'd0, 2'b11); idle(12);
    wr(4'd3, 2'b10); idle(12);
    wr(4'd1, 2'b11); idle(12);
    wr(4'd4, 2'b10); idle(12);
    wr(4'd2, 2'b11);
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL row_done_n1: got %b expected 0", done1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL row_busy_n1: got %b expected 1", busy1); end
    checks++; if (board1 !== 18'h002BF) begin failures++; $display("FAIL row_board: got %h expected %h", board1, 18'h002BF); end
    step();
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL row_done_n2: got %b expected 1", done1); end
    checks++; if (win1 !== 2'b11) begin failures++; $display("FAIL row_winner_n2: got %b expected 11", win1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL row_busy_n2: got %b expected 0", busy1); end
    idle(5);
    checks++; if (done1 !== 1'b1 || win1 !== 2'b11) begin failures++; $display("FAIL row_hold: got done=%b winner=%b expected done=1 winner=11", done1, win1); end
    wr(4'd5, 2'b10);
    checks++; if (ill1 !== 1'b0) begin failures++; $display("FAIL done_write_illegal: got %b expected 0", ill1); end
    checks++; if (board1 !== 18'h002BF) begin failures++; $display("FAIL done_write_board: got %h expected %h", board1, 18'h002BF); end
  endtask

  task automatic test_diag_win();
    apply_reset();
    wr(4'd0, 2'b11); idle(10);
    wr(4'd2, 2'b10); idle(10);
    wr(4'd1, 2'b11); idle(10);
    wr(4'd4, 2'b10); idle(10);
    wr(4'd8, 2'b11); idle(10);
    wr(4'd6, 2'b10);
    checks++; if (done1 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL diag_done_n1: got l1=%b l8=%b expected 0 0", done1, done8); end
    step();
    checks++; if (done8 !== 1'b1) begin failures++; $display("FAIL diag_l8_done_n2: got %b expected 1", done8); end
    checks++; if (win8 !== 2'b10) begin failures++; $display("FAIL diag_l8_winner_n2: got %b expected 10", win8); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL diag_l1_done_n2: got %b expected 0", done1); end
    idle(6);
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL diag_l1_n8: got done=%b busy=%b expected done=0 busy=1", done1, busy1); end
    step();
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL diag_l1_done_n9: got %b expected 1", done1); end
    checks++; if (win1 !== 2'b10) begin failures++; $display("FAIL diag_l1_winner_n9: got %b expected 10", win1); end
  endtask

  task automatic test_tie();
    logic [3:0] seq_a [9];
    logic [1:0] seq_s [9];
    seq_a = '{4'd0, 4'd2, 4'd1, 4'd3, 4'd5, 4'd4, 4'd6, 4'd7, 4'd8};
    seq_s = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      wr(seq_a[i], seq_s[i]);
      idle(10);
    end
    checks++; if (done1 !== 1'b0 || win1 !== 2'b00) begin failures++; $display("FAIL tie_premature: got done=%b winner=%b expected done=0 winner=00", done1, win1); end
    wr(seq_a[8], seq_s[8]);
    step();
    checks++; if (done8 !== 1'b1 || win8 !== 2'b01) begin failures++; $display("FAIL tie_l8_n2: got done=%b winner=%b expected done=1 winner=01", done8, win8); end
    idle(6);
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL tie_l1_done_n8: got %b expected 0", done1); end
    step();
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL tie_l1_done_n9: got %b expected 1", done1); end
    checks++; if (win1 !== 2'b01) begin failures++; $display("FAIL tie_l1_winner_n9: got %b expected 01", win1); end
  endtask

  task automatic test_illegal();
    apply_reset();
    wr(4'd0, 2'b11); idle(10);
    wr(4'd0, 2'b10);
    checks++; if (ill1 !== 1'b1) begin failures++; $display("FAIL occupied_pulse: got %b expected 1", ill1); end
    checks++; if (board1 !== 18'h00003) begin failures++; $display("FAIL occupied_board: got %h expected %h", board1, 18'h00003); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL occupied_busy: got %b expected 0", busy1); end
    step();
    checks++; if (ill1 !== 1'b0) begin failures++; $display("FAIL occupied_pulse_end: got %b expected 0", ill1); end
    wr(4'd9, 2'b11);
    checks++; if (ill1 !== 1'b1) begin failures++; $display("FAIL addr9_pulse: got %b expected 1", ill1); end
    step();
    checks++; if (ill1 !== 1'b0) begin failures++; $display("FAIL addr9_pulse_end: got %b expected 0", ill1); end
    wr(4'd1, 2'b00);
    checks++; if (ill1 !== 1'b1 || board1 !== 18'h00003) begin failures++; $display("FAIL empty_write: got illegal=%b board=%h expected illegal=1 board=%h", ill1, board1, 18'h00003); end
    step();
    wr(4'hF, 2'b11);
    checks++; if (ill1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL nowrite: got illegal=%b busy=%b expected 0 0", ill1, busy1); end
    // moveCount untouched by rejects: one legal move leaves a 9-move tie impossible here, so
    // check the next legal write is accepted and scanned normally.
    wr(4'd1, 2'b10);
    checks++; if (board1 !== 18'h0000B || busy1 !== 1'b1) begin failures++; $display("FAIL after_reject_write: got board=%h busy=%b expected board=%h busy=1", board1, busy1, 18'h0000B); end
  endtask

  task automatic test_restart_and_reset();
    apply_reset();
    wr(4'd0, 2'b11);
    step();
    step();
    wr(4'd1, 2'b10);
    for (int i = 0; i < 8; i++) begin
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL restart_busy_%0d: got %b expected 1", i, busy1); end
      step();
    end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL restart_busy_end: got %b expected 0", busy1); end
    wr(4'd2, 2'b11);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (board1 !== 18'h0) begin failures++; $display("FAIL midscan_reset_board: got %h expected %h", board1, 18'h0); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL midscan_reset_busy: got %b expected 0", busy1); end
    checks++; if (win1 !== 2'b00 || done1 !== 1'b0) begin failures++; $display("FAIL midscan_reset_result: got winner=%b done=%b expected 00 0", win1, done1); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    addr      = 4'hF;
    cellState = 2'b00;
    test_reset();
    test_row_win();
    test_diag_win();
    test_tie();
    test_illegal();
    test_restart_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_judge.md
Name: board_judge

Overview:
- Responder end of the game controller's board-write interface: accepts (addr, cellState) cell writes, holds the 3x3 board, and returns gameIsDone and winner back to the controller.
- After every accepted move it runs a multi-cycle scan of the 8 winning lines and detects the win/tie result.
- Sits between the game controller and the board display/AI logic, which read the board through the board output.

Parameters:
LINES_PER_CYCLE, 1, winning lines evaluated per scan cycle; legal values 1, 2, 4, 8; a scan takes 8/LINES_PER_CYCLE cycles.

Ports:
ph1  input  1  phase 1 of the single two-phase system clock; ph1/ph2 are the one clock, and all state uses the standard two-phase flop.
ph2  input  1  phase 2 of the same clock.
reset  input  1  synchronous, active-high; sampled on the clock edge through the state-register reset mux.
addr  input  4  cell address, row-major r*3+c for 0..8; 4'b1111 means no write.
cellState  input  2  value to write: 00 EMPTY, 11 O (player1), 10 X (player2).
gameIsDone  output  1  result valid; held until reset.
winner  output  2  11 player1, 10 player2, 01 tie, 00 no result.
illegalMove  output  1  one-cycle pulse when a write is rejected.
busy  output  1  high while the scan FSM is in SCAN.
board  output  18  board[2i+1:2i] = cell i.

Behaviour:
- Reset (synchronous, any state including mid-scan):
  - all cells EMPTY and moveCount = 0;
  - FSM goes to IDLE and the line index is cleared;
  - gameIsDone = 0, winner = 00, illegalMove = 0, busy = 0.
- Write request: addr != 4'b1111 in any cycle while the FSM is not DONE.
- A write is accepted only if all of the following hold:
  - addr <= 8;
  - cellState != EMPTY;
  - the target cell is EMPTY.
- An accepted write in cycle N:
  - the cell is updated and visible on board from N+1;
  - moveCount increments;
  - the FSM enters SCAN at line index 0 in N+1.
- Rejected write (addr 9..14, cellState EMPTY, or occupied cell): board and moveCount unchanged; illegalMove = 1 in N+1 only.
- addr 4'b1111: no action and no illegalMove.
- Line order:
  - 0: 0-1-2; 1: 3-4-5; 2: 6-7-8 (rows);
  - 3: 0-3-6; 4: 1-4-7; 5: 2-5-8 (columns);
  - 6: 0-4-8; 7: 2-4-6 (diagonals).
- A line wins when all 3 cells are equal and non-EMPTY; winner takes the cell value directly.
- FSM IDLE: waits for an accepted write, then goes to SCAN.
- FSM SCAN, scan cycle k evaluates lines k*L .. k*L+L-1, where L = LINES_PER_CYCLE:
  - On any win: winner is set and gameIsDone = 1 from the next cycle, and the FSM goes to DONE. If several lines win in one cycle, the lowest index decides; all winning cells share one value, so the result is the same.
  - After the last group with no win: if moveCount == 9, winner = 01 and gameIsDone = 1 next cycle, FSM goes to DONE; otherwise FSM returns to IDLE with winner 00.
  - An accepted write during SCAN is applied and restarts the scan at line index 0 in the next cycle.
- FSM DONE: all writes are ignored silently (no board change, no illegalMove); the FSM stays in DONE until reset.
- busy = 1 exactly in the SCAN state.
- Latency with L = 1: a win on line i from a write in cycle N gives gameIsDone at N+2+i; a tie gives gameIsDone at N+9.
- moveCount is 4 bits and saturates logically at 9; no write can be accepted once the board is full.

Test Plan:
- Reset: hold reset 2 cycles, then idle -> board = 0, gameIsDone = 0, winner = 00, busy = 0, illegalMove = 0.
- Row win for O: writes O@0, X@3, O@1, X@4, O@2, with the final write in cycle N and idle gaps of 10+ cycles -> gameIsDone = 1 and winner = 11 at N+2, and they stay set.
- Diagonal win for X (line 7, L = 1): final X@6 with X@2, X@4 placed, cycle N -> gameIsDone = 1 and winner = 10 at N+9; with LINES_PER_CYCLE = 8 -> N+2.
- Tie: O@0,1,5,6,8 and X@2,3,4,7, last write in cycle N -> winner = 01 and gameIsDone = 1 at N+9.
- Illegal writes:
  - O@0 then X@0 -> illegalMove pulses one cycle, cell 0 stays 11, moveCount unchanged;
  - addr 9 -> illegalMove pulses;
  - addr 15 -> no pulse.
- Restart and reset:
  - a legal write 3 cycles into a scan -> scan restarts at line 0 and busy stays high 8 more cycles;
  - reset asserted mid-scan -> next cycle board = 0, busy = 0, winner = 00.
